// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, instruction handshake to the
// control unit, branch redirect inputs, halt and PC trace output.
interface instr_fetch_unit_if #(
  parameter int unsigned PC_WIDTH    = 12,
  parameter int unsigned INSTR_WIDTH = 16
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instr_valid;
  logic                   instr_ready;
  logic                   load_pc;
  logic [PC_WIDTH-1:0]    load_pc_val;
  logic                   halt;
  logic [PC_WIDTH-1:0]    pc;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instruction, instr_valid, pc,
    input  imem_ack, imem_rdata, instr_ready, load_pc, load_pc_val, halt
  );

  // Memory / control-unit side
  modport slave (
    input  imem_req, imem_addr, instruction, instr_valid, pc,
    output imem_ack, imem_rdata, instr_ready, load_pc, load_pc_val, halt
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a
// req/ack port and presents one instruction at a time to the control unit.
module instr_fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 12,
  parameter int unsigned         INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input logic             clk,
  input logic             rst,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;

  logic [PC_WIDTH-1:0]    pc_q;
  logic [PC_WIDTH-1:0]    pc_d;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [INSTR_WIDTH-1:0] instr_d;
  logic                   req_q;
  logic                   req_d;
  logic                   valid_q;
  logic                   valid_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the unused encoding falls back to idle
  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:  state_next = bus.halt ? S_IDLE : S_REQ;
      S_REQ:   state_next = bus.imem_ack ? S_VALID : S_REQ;
      S_VALID: begin
        if (bus.instr_ready) begin
          state_next = bus.halt ? S_IDLE : S_REQ;
        end else begin
          state_next = S_VALID;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output/datapath next values; req and valid follow the next state so they
  // are registered alongside it, and a branch beats the sequential increment
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    req_d   = (state_next == S_REQ);
    valid_d = (state_next == S_VALID);
    case (state)
      S_REQ: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
        end
      end
      S_VALID: begin
        if (bus.instr_ready) begin
          pc_d = bus.load_pc ? bus.load_pc_val : pc_q + PC_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;

endmodule
